// File: rtl/memory_reader.sv
// Burst read engine in front of a synchronous ROM: issues reads, buffers the returned words
// and streams them out on valid/ready. Define MEMORY_READER_LOOP_EN to enable loop mode.
module memory_reader #(
    parameter int BIT_WIDTH     = 8,
    parameter int ADDRESS_WIDTH = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_read,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [BIT_WIDTH-1:0]     mem_q,
    output logic [BIT_WIDTH-1:0]     out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               dbg_state
);
    // Stream handshake: out_data is transferred on every rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready, and the head word holds until it is accepted.

    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [ADDRESS_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [PW-1:0]            PTR_ONE  = 1;
    localparam logic [PW:0]              OCC_ONE  = 1;
    localparam logic [PW:0]              OCC_MAX  = FIFO_DEPTH[PW:0];

    logic [1:0]               state, state_nxt;
    logic [ADDRESS_WIDTH:0]   issue_cnt, accept_cnt;
    logic                     inflight;
    logic [BIT_WIDTH-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [PW:0]              count;
    logic [PW:0]              occ_sum;
    logic                     push, pop, accept_start, zero_start, last_accept, restart;

`ifdef MEMORY_READER_LOOP_EN
    logic [ADDRESS_WIDTH-1:0] base_q;
    logic [ADDRESS_WIDTH:0]   len_q;
    assign restart = start;
`else
    assign restart = 1'b0;
`endif

    // Stage 1 of the read pipe is the issue cycle itself (mem_read); stage 2 is inflight,
    // the cycle in which mem_q carries the word and is pushed into the buffer.
    assign occ_sum      = count + {{PW{1'b0}}, inflight};
    assign mem_read     = (state == RUN) && (issue_cnt != '0) && (occ_sum < OCC_MAX);
    assign push         = inflight;
    assign out_valid    = (count != '0);
    assign pop          = out_valid && out_ready;
    assign out_data     = fifo_mem[rd_ptr];
    assign accept_start = (state == IDLE) && start && (length != '0);
    assign zero_start   = (state == IDLE) && start && (length == '0);
    assign last_accept  = (state == DRAIN) && pop && (accept_cnt == CNT_ONE);
    assign dbg_state    = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_start) state_nxt = RUN;
            RUN:     if (mem_read && issue_cnt == CNT_ONE) state_nxt = DRAIN;
            DRAIN:   if (last_accept) state_nxt = restart ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_addr   <= '0;
            issue_cnt  <= '0;
            accept_cnt <= '0;
            inflight   <= 1'b0;
`ifdef MEMORY_READER_LOOP_EN
            base_q     <= '0;
            len_q      <= '0;
`endif
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != IDLE);
            done     <= zero_start || last_accept;
            inflight <= mem_read;
            if (accept_start) begin
                mem_addr   <= base_addr;
                issue_cnt  <= length;
                accept_cnt <= length;
`ifdef MEMORY_READER_LOOP_EN
                base_q     <= base_addr;
                len_q      <= length;
            end else if (last_accept && restart) begin
                mem_addr   <= base_q;
                issue_cnt  <= len_q;
                accept_cnt <= len_q;
`endif
            end else begin
                if (mem_read) begin
                    mem_addr  <= mem_addr + ADDR_ONE;
                    issue_cnt <= issue_cnt - CNT_ONE;
                end
                if (pop && accept_cnt != '0) accept_cnt <= accept_cnt - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= mem_q;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + OCC_ONE;
                2'b01:   count <= count - OCC_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_reader.sv
// Directed bench for memory_reader with a behavioural ROM holding q = addr*0x11.
// Define MEMORY_READER_LOOP_EN to also exercise loop mode.
module tb_memory_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] base_addr = '0;
  logic [3:0] length = '0;
  logic       busy, done, mem_read, out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] mem_addr;
  logic [7:0] mem_q = '0;
  logic [7:0] out_data;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  int n_read, n_done, n_busy, first_valid, cyc;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  memory_reader #(.BIT_WIDTH(8), .ADDRESS_WIDTH(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_read(mem_read), .mem_addr(mem_addr), .mem_q(mem_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // synchronous ROM, q = addr * 0x11
  always_ff @(posedge clk) begin
    if (mem_read) mem_q <= {1'b0, mem_addr, 1'b0, mem_addr};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_stats();
    n_read = 0; n_done = 0; n_busy = 0; first_valid = -1; cyc = 0;
    got_q.delete();
  endtask

  // sample at negedge (values seen by the next edge), then step past the edge
  task automatic cycle();
    @(negedge clk);
    if (mem_read) n_read++;
    if (done) n_done++;
    if (busy) n_busy++;
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (out_valid && out_ready) got_q.push_back(out_data);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic launch(input logic [2:0] b, input logic [3:0] l);
    clear_stats();
    start = 1'b1; base_addr = b; length = l;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin cycle(); k++; end
    check({tag, "_done_seen"}, 32'(n_done != 0), 32'd1);
    repeat (3) cycle();
  endtask

  // scoreboard: compare captured stream against the expected queue
  task automatic check_words(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_mem_read", 32'(mem_read), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_state", 32'(dbg_state), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // plain burst
    launch(3'd2, 4'd4);
    wait_done("plain", 30);
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
    check_words("plain");
    check("plain_first_valid", 32'(first_valid), 32'd3);
    check("plain_done_pulses", 32'(n_done), 32'd1);
    check("plain_busy_cycles", 32'(n_busy), 32'd6);
    check("plain_reads", 32'(n_read), 32'd4);

    // wrap-around
    launch(3'd6, 4'd4);
    wait_done("wrap", 30);
    exp_q = '{8'h66, 8'h77, 8'h00, 8'h11};
    check_words("wrap");
    check("wrap_busy_cycles", 32'(n_busy), 32'd6);

    // full memory
    launch(3'd0, 4'd8);
    wait_done("full", 40);
    exp_q = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    check_words("full");
    check("full_reads", 32'(n_read), 32'd8);
    check("full_busy_cycles", 32'(n_busy), 32'd10);
    check("full_done_pulses", 32'(n_done), 32'd1);

    // back-pressure: ready low for 10 cycles after start
    out_ready = 1'b0;
    launch(3'd1, 4'd6);
    repeat (9) cycle();
    check("bp_stalled_reads", 32'(n_read), 32'd4);
    check("bp_stalled_words", 32'(got_q.size()), 32'd0);
    check("bp_stalled_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_done("bp", 40);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    check_words("bp");
    check("bp_reads", 32'(n_read), 32'd6);
    check("bp_done_pulses", 32'(n_done), 32'd1);

    // zero length
    launch(3'd4, 4'd0);
    wait_done("zero", 5);
    check("zero_done_pulses", 32'(n_done), 32'd1);
    check("zero_busy_cycles", 32'(n_busy), 32'd0);
    check("zero_reads", 32'(n_read), 32'd0);
    check("zero_words", 32'(got_q.size()), 32'd0);

    // start mid-burst is ignored
    launch(3'd0, 4'd3);
    cycle();
    start = 1'b1; base_addr = 3'd5; length = 4'd2;
    cycle();
    start = 1'b0;
    wait_done("ign", 30);
    exp_q = '{8'h00, 8'h11, 8'h22};
    check_words("ign");
    check("ign_reads", 32'(n_read), 32'd3);
    check("ign_done_pulses", 32'(n_done), 32'd1);
    check("ign_busy_cycles", 32'(n_busy), 32'd5);

    // reset mid-burst
    launch(3'd3, 4'd5);
    k = 0;
    while (got_q.size() < 2 && k < 20) begin cycle(); k++; end
    check("mid_two_words", 32'(got_q.size()), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_mem_read", 32'(mem_read), 0);
    check("mid_rst_mem_addr", 32'(mem_addr), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_data", 32'(out_data), 0);
    check("mid_rst_state", 32'(dbg_state), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    launch(3'd0, 4'd3);
    wait_done("post_rst", 30);
    exp_q = '{8'h00, 8'h11, 8'h22};
    check_words("post_rst");
    check("post_rst_reads", 32'(n_read), 32'd3);

`ifdef MEMORY_READER_LOOP_EN
    // loop mode: start held through the first final accept
    clear_stats();
    start = 1'b1; base_addr = 3'd2; length = 4'd2;
    k = 0;
    while (n_done == 0 && k < 30) begin cycle(); k++; end
    start = 1'b0;
    k = 0;
    while (n_done < 2 && k < 30) begin cycle(); k++; end
    repeat (3) cycle();
    exp_q = '{8'h22, 8'h33, 8'h22, 8'h33};
    check_words("loop");
    check("loop_done_pulses", 32'(n_done), 32'd2);
    check("loop_busy_cycles", 32'(n_busy), 32'd8);
    check("loop_reads", 32'(n_read), 32'd4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_reader.md
# memory_reader

Burst read engine that sits directly upstream of the synchronous `memory` ROM. It drives that memory's `read`/`addr` inputs and captures its `q` output one cycle later. Captured words are buffered and presented to downstream logic on a valid/ready stream. A burst is started by a one-cycle command giving a base address and a word count, and is completed with a `done` pulse.

## Interface
Parameters:
- `BIT_WIDTH`, 8 — data word width; must match the memory.
- `ADDRESS_WIDTH`, 3 — memory address width.
- `FIFO_DEPTH`, 4 — output buffer entries; power of two, ≥ 4.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — burst request; sampled only in IDLE.
- `base_addr`  in  ADDRESS_WIDTH  — first address; captured when `start` is accepted.
- `length`  in  ADDRESS_WIDTH+1  — words in the burst, 0..2^ADDRESS_WIDTH; captured with `start`.
- `busy`  out  1  — high in RUN or DRAIN.
- `done`  out  1  — one-cycle pulse after the last word is accepted downstream.
- `mem_read`  out  1  — read enable to the memory.
- `mem_addr`  out  ADDRESS_WIDTH  — address to the memory.
- `mem_q`  in  BIT_WIDTH  — memory data, valid the cycle after the memory samples `mem_read`=1.
- `out_data`  out  BIT_WIDTH  — head of the output buffer.
- `out_valid`  out  1  — buffer not empty.
- `out_ready`  in  1  — downstream accepts `out_data` when `out_valid && out_ready` at the edge.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE → RUN:** on `start`=1 with `length`≠0. Captures `base_addr` into the address counter and `length` into both the issue counter and the accept counter.
- **Zero-length start:** `start`=1 with `length`=0 stays in IDLE and pulses `done` the next cycle.
- **`start` while busy:** ignored; it is not queued.
- **RUN issue rule:** `mem_read`=1 when issue counter ≠ 0 and (buffer occupancy + in-flight reads) < FIFO_DEPTH.
  - Each issue increments `mem_addr` by 1 modulo 2^ADDRESS_WIDTH. A burst from address 7 with `length` 3 reads 7, 0, 1.
  - Each issue also decrements the issue counter.
- **In-flight tracking:** a 2-stage valid shift register tracks outstanding reads. Stage 2 writes `mem_q` into the buffer.
- **RUN → DRAIN:** when the issue counter reaches 0.
- **DRAIN → IDLE:** on the edge where the final word is accepted, i.e. the accept counter goes 1 → 0. `done`=1 in the following cycle.
- **Buffer:** FIFO, first-in first-out, no data reordering or loss.
  - Simultaneous push and pop is legal at any occupancy, including full.
  - Overflow is impossible by the issue rule.
- **Address/width rules:**
  - Address arithmetic wraps silently.
  - Counters are ADDRESS_WIDTH+1 bits, so a full-memory burst (`length`=2^ADDRESS_WIDTH) is legal.
- **Reset:** asserting `rst_n` low at any time, including mid-burst, immediately clears all state.
  - In-flight data is discarded.
  - The buffer is emptied.
  - State returns to IDLE.

## Timing
- **Reset values:**
  - `busy`=0, `done`=0, `mem_read`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0.
  - All counters 0, state IDLE.
- **Output sourcing:**
  - `mem_read` is combinational from registered state and counters.
  - `mem_addr`, `busy`, `done` and `out_data` are registered, or FIFO-head registered.
- **Start sampled at edge E0:**
  - `busy`=1 and `mem_read`=1 with `mem_addr`=`base_addr` during the E0–E1 cycle.
  - The memory samples at E1.
  - The reader captures `mem_q` at E2.
  - `out_valid`=1 after E2.
  - Latency from start to first valid: 2 cycles.
- **Throughput:** with `out_ready` held 1, one word per cycle, and `busy` spans `length`+2 cycles.
- **Back-pressure:** with `out_ready`=0, issue stops once occupancy + in-flight = FIFO_DEPTH. Issue resumes the cycle after a pop.
- **`done` pulse:** exactly one cycle wide. `busy`=0 in the same cycle as `done`. A new `start` is accepted in the `done` cycle.

## Configuration
- **`MEMORY_READER_LOOP_EN`** — enables loop mode.
- **Defined:**
  - If `start`=1 on the edge where the final word is accepted, the engine reloads the captured base/length and re-enters RUN directly.
  - New `base_addr`/`length` are not sampled.
  - `done` still pulses once per pass; `busy` stays 1 across passes.
- **Not defined:** the engine always returns to IDLE and requires a fresh `start`.

## Test plan
The bench memory holds `q` = addr×0x11.
- **Plain burst:** reset, then `start` with `base_addr`=2, `length`=4, `out_ready`=1.
  - `out_data` sequence: 22, 33, 44, 55 on consecutive cycles.
  - First `out_valid` 2 cycles after start.
  - Single `done` pulse.
  - `busy` high for 6 cycles.
- **Wrap-around:** `base_addr`=6, `length`=4 → 66, 77, 00, 11.
- **Full memory:** `length`=8 → 8 words in address order, no extra `mem_read`.
- **Back-pressure:** `out_ready`=0 for 10 cycles after start, then 1.
  - Exactly 4 reads issued while stalled.
  - No word lost or duplicated.
  - Order preserved.
- **Zero length and ignored start:**
  - `length`=0 → `done` pulse, `busy` never 1, no `mem_read`.
  - `start` pulsed mid-burst → ignored.
- **Reset mid-burst:** `rst_n` low after 2 words.
  - All outputs immediately return to their reset values.
  - A subsequent burst of 0x0..0x2 returns 00, 11, 22.
- **Loop mode (`MEMORY_READER_LOOP_EN`):** `start` held 1 → two passes with two `done` pulses and `busy` continuous.
